// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter: data port (m0) and instruction fetch (m1) share one slave.
// Round-robin on simultaneous requests; define ARB_FIXED_PRIORITY_EN to make m0 always win ties.
module avalon_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest,
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state_q, state_d;
  logic   lastOwner_q, lastOwner_d;
  logic   req0, req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // lastOwner starts at m1 so that m0 wins the very first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lastOwner_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      lastOwner_q <= lastOwner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lastOwner_d = lastOwner_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
`ifdef ARB_FIXED_PRIORITY_EN
          state_d = OWN0;
`else
          state_d = lastOwner_q ? OWN0 : OWN1;
`endif
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!req0) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d     = IDLE;
          lastOwner_d = 1'b0;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d     = IDLE;
          lastOwner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave-side mux: address/data default to m0, strobes only come from the owner.
  always_comb begin
    s_address    = m0_address;
    s_byteenable = m0_byteenable;
    s_writedata  = m0_writedata;
    s_read       = 1'b0;
    s_write      = 1'b0;
    case (state_q)
      OWN0: begin
        s_read  = m0_read;
        s_write = m0_write;
      end
      OWN1: begin
        s_address    = m1_address;
        s_byteenable = m1_byteenable;
        s_writedata  = m1_writedata;
        s_read       = m1_read;
        s_write      = m1_write;
      end
      default: ;
    endcase
  end

  always_comb begin
    grant          = {state_q == OWN1, state_q == OWN0};
    m0_readdata    = s_readdata;
    m1_readdata    = s_readdata;
    m0_waitrequest = req0 && ((state_q == OWN0) ? s_waitrequest : 1'b1);
    m1_waitrequest = req1 && ((state_q == OWN1) ? s_waitrequest : 1'b1);
  end

  m0RwExclusive: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write))
    else $error("avalon_bus_arbiter: m0_read and m0_write asserted together");
  m1RwExclusive: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write))
    else $error("avalon_bus_arbiter: m1_read and m1_write asserted together");

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter: scripted masters, a wait-state slave model
// and a scoreboard of completed slave transfers.
module tb_avalon_bus_arbiter;

  typedef struct packed {
    logic [1:0]  grant;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } xfer_t;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [1:0]  grant;

  int    total = 0;
  int    bad = 0;
  int    slaveWaits = 0;
  int    waitCnt = 0;
  logic [31:0] slaveData = 32'h0;
  xfer_t expQ[$];
  xfer_t obsQ[$];

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave holds waitrequest for slaveWaits cycles of each access.
  assign s_waitrequest = (waitCnt < slaveWaits);
  assign s_readdata    = slaveData;

  // Records every completed slave transfer and advances the slave wait counter.
  always begin : monitor
    int  nextCnt;
    logic active;
    xfer_t o;
    @(negedge clk);
    #3;
    active = (s_read || s_write) && !reset;
    nextCnt = 0;
    if (active && !s_waitrequest) begin
      o.grant = grant;
      o.wr    = s_write;
      o.addr  = s_address;
      o.be    = s_byteenable;
      o.wdata = s_write ? s_writedata : 32'h0;
      o.rdata = s_read ? (grant[1] ? m1_readdata : m0_readdata) : 32'h0;
      obsQ.push_back(o);
    end else if (active) begin
      nextCnt = waitCnt + 1;
    end
    @(posedge clk);
    #1;
    waitCnt = nextCnt;
  end

  task automatic clearMasters();
    m0_address = 32'h0; m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = 4'h0; m0_writedata = 32'h0;
    m1_address = 32'h0; m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = 4'h0; m1_writedata = 32'h0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    clearMasters();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      total++;
      if (grant !== 2'b00 || s_read !== 1'b0 || s_write !== 1'b0 || m0_waitrequest !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle c%0d: grant=%b rd=%b wr=%b m0w=%b, want 00 0 0 0",
                 c, grant, s_read, s_write, m0_waitrequest);
      end
    end
  endtask

  task automatic test_m1_read();
    int   waitHigh = 0;
    bit   done = 0;
    logic [1:0] g1 = 2'bxx;
    xfer_t e, o;
    slaveWaits = 2;
    slaveData  = 32'h8C420004;
    @(negedge clk);
    m1_address = 32'hBFC00000; m1_byteenable = 4'hF; m1_read = 1'b1;
    expQ.push_back('{grant: 2'b10, wr: 1'b0, addr: 32'hBFC00000, be: 4'hF, wdata: 32'h0, rdata: 32'h8C420004});
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (c == 1) g1 = grant;
      if (m1_waitrequest) waitHigh++;
      else done = 1;
    end
    @(negedge clk);
    m1_read = 1'b0;
    #2;
    total++;
    if (!done) begin bad++; $display("[TB] FAIL m1_read_timeout: completed=0, want 1"); end
    total++;
    if (g1 !== 2'b10) begin bad++; $display("[TB] FAIL m1_read_grant: got %b, want 10", g1); end
    total++;
    if (waitHigh != 3) begin bad++; $display("[TB] FAIL m1_read_wait: got %0d cycles, want 3", waitHigh); end
    total++;
    if (grant !== 2'b00) begin bad++; $display("[TB] FAIL m1_read_idle: got %b, want 00", grant); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("[TB] FAIL m1_read_xfer: got none, want %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL m1_read_xfer: got %h, want %h", o, e); end
      end
    end
    total++;
    if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL m1_read_extra: got %0d, want 0", obsQ.size()); obsQ.delete(); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] gSeq [5];
    logic [1:0] want [5];
    logic m1Held = 1'b1;
    bit drop0 = 0, drop1 = 0;
    xfer_t e, o;
    want = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    doReset();
    slaveWaits = 0;
    slaveData  = 32'h0BADF00D;
    @(negedge clk);
    m0_address = 32'h00001000; m0_byteenable = 4'hF; m0_writedata = 32'h12345678; m0_write = 1'b1;
    m1_address = 32'hBFC00000; m1_byteenable = 4'hF; m1_read = 1'b1;
    expQ.push_back('{grant: 2'b01, wr: 1'b1, addr: 32'h00001000, be: 4'hF, wdata: 32'h12345678, rdata: 32'h0});
    expQ.push_back('{grant: 2'b10, wr: 1'b0, addr: 32'hBFC00000, be: 4'hF, wdata: 32'h0, rdata: 32'h0BADF00D});
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (drop0) m0_write = 1'b0;
      if (drop1) m1_read = 1'b0;
      #2;
      gSeq[c] = grant;
      if (c < 2) m1Held = m1Held & m1_waitrequest;
      if (m0_write && !m0_waitrequest) drop0 = 1;
      if (m1_read && !m1_waitrequest) drop1 = 1;
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (gSeq[c] !== want[c]) begin bad++; $display("[TB] FAIL simul_grant c%0d: got %b, want %b", c, gSeq[c], want[c]); end
    end
    total++;
    if (m1Held !== 1'b1) begin bad++; $display("[TB] FAIL simul_m1_stall: got %b, want 1", m1Held); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("[TB] FAIL simul_xfer: got none, want %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL simul_xfer: got %h, want %h", o, e); end
      end
    end
    total++;
    if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL simul_extra: got %0d, want 0", obsQ.size()); obsQ.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] gSeq [9];
    logic [1:0] want [9];
    xfer_t e, o;
    xfer_t x0, x1;
    slaveWaits = 0;
    slaveData  = 32'hCAFE0000;
    x0 = '{grant: 2'b01, wr: 1'b0, addr: 32'h00000100, be: 4'hF, wdata: 32'h0, rdata: 32'hCAFE0000};
    x1 = '{grant: 2'b10, wr: 1'b0, addr: 32'h00000200, be: 4'hF, wdata: 32'h0, rdata: 32'hCAFE0000};
`ifdef ARB_FIXED_PRIORITY_EN
    want = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    repeat (4) expQ.push_back(x0);
`else
    want = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    repeat (2) begin expQ.push_back(x0); expQ.push_back(x1); end
`endif
    @(negedge clk);
    m0_address = 32'h00000100; m0_byteenable = 4'hF; m0_read = 1'b1;
    m1_address = 32'h00000200; m1_byteenable = 4'hF; m1_read = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      gSeq[c] = grant;
    end
    @(negedge clk);
    m0_read = 1'b0; m1_read = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 9; c++) begin
      total++;
      if (gSeq[c] !== want[c]) begin bad++; $display("[TB] FAIL b2b_grant c%0d: got %b, want %b", c, gSeq[c], want[c]); end
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("[TB] FAIL b2b_xfer: got none, want %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL b2b_xfer: got %h, want %h", o, e); end
      end
    end
    total++;
    if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL b2b_extra: got %0d, want 0", obsQ.size()); obsQ.delete(); end
  endtask

  task automatic test_reset_mid();
    bit done = 0;
    xfer_t e, o;
    slaveWaits = 5;
    @(negedge clk);
    m0_address = 32'h00002000; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF; m0_write = 1'b1;
    expQ.push_back('{grant: 2'b01, wr: 1'b1, addr: 32'h00002000, be: 4'hF, wdata: 32'hDEADBEEF, rdata: 32'h0});
    @(negedge clk);
    reset = 1'b1;
    #2;
    total++;
    if (grant !== 2'b01 || s_write !== 1'b1) begin
      bad++; $display("[TB] FAIL rstmid_pre: grant=%b wr=%b, want 01 1", grant, s_write);
    end
    @(negedge clk);
    reset = 1'b0;
    slaveWaits = 1;
    #2;
    total++;
    if (grant !== 2'b00 || s_write !== 1'b0 || m0_waitrequest !== 1'b1) begin
      bad++; $display("[TB] FAIL rstmid_idle: grant=%b wr=%b m0w=%b, want 00 0 1", grant, s_write, m0_waitrequest);
    end
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      #2;
      if (!m0_waitrequest) done = 1;
    end
    @(negedge clk);
    m0_write = 1'b0;
    @(negedge clk);
    total++;
    if (!done) begin bad++; $display("[TB] FAIL rstmid_retry_timeout: completed=0, want 1"); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("[TB] FAIL rstmid_xfer: got none, want %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL rstmid_xfer: got %h, want %h", o, e); end
      end
    end
    total++;
    if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL rstmid_extra: got %0d, want 0", obsQ.size()); obsQ.delete(); end
  endtask

  task automatic test_long_stall();
    int stall = 0;
    int grantBad = 0;
    int m1Bad = 0;
    bit done0 = 0, done1 = 0;
    xfer_t e, o;
    slaveWaits = 20;
    slaveData  = 32'h5A5A1234;
    expQ.push_back('{grant: 2'b01, wr: 1'b0, addr: 32'h00003000, be: 4'hF, wdata: 32'h0, rdata: 32'h5A5A1234});
    expQ.push_back('{grant: 2'b10, wr: 1'b0, addr: 32'h00004000, be: 4'hF, wdata: 32'h0, rdata: 32'h5A5A1234});
    @(negedge clk);
    m0_address = 32'h00003000; m0_byteenable = 4'hF; m0_read = 1'b1;
    for (int c = 0; c < 60 && !done0; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) begin m1_address = 32'h00004000; m1_byteenable = 4'hF; m1_read = 1'b1; end
      #2;
      if (c >= 1 && grant !== 2'b01) grantBad++;
      if (c >= 2 && m1_waitrequest !== 1'b1) m1Bad++;
      if (m0_waitrequest) stall++;
      else done0 = 1;
    end
    @(negedge clk);
    m0_read = 1'b0;
    slaveWaits = 0;
    for (int c = 0; c < 20 && !done1; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (!m1_waitrequest) done1 = 1;
    end
    @(negedge clk);
    m1_read = 1'b0;
    @(negedge clk);
    total++;
    if (!done0 || !done1) begin bad++; $display("[TB] FAIL stall_timeout: done0=%0d done1=%0d, want 1 1", done0, done1); end
    total++;
    if (stall != 21) begin bad++; $display("[TB] FAIL stall_cycles: got %0d, want 21", stall); end
    total++;
    if (grantBad != 0) begin bad++; $display("[TB] FAIL stall_grant: got %0d off cycles, want 0", grantBad); end
    total++;
    if (m1Bad != 0) begin bad++; $display("[TB] FAIL stall_m1_wait: got %0d low cycles, want 0", m1Bad); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("[TB] FAIL stall_xfer: got none, want %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL stall_xfer: got %h, want %h", o, e); end
      end
    end
    total++;
    if (obsQ.size() != 0) begin bad++; $display("[TB] FAIL stall_extra: got %0d, want 0", obsQ.size()); obsQ.delete(); end
  endtask

  initial begin
    reset = 1'b1;
    clearMasters();
    test_reset();
    test_m1_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_long_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
